// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter slice.
// Holds the bus widths, the FSM state encoding and the read data returned on a timeout.
package apb_arb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr, cyclically.
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int          cand;
  logic [IW-1:0] candIdx;
  logic        found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand    = (int'(ptr) + k) % NREQ;
      candIdx = IW'(cand);
      if (en && !found && req[candIdx]) begin
        found        = 1'b1;
        gnt[candIdx] = 1'b1;
        idx          = candIdx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB3 master port between NREQ requesters.
// Each transfer runs SETUP then ACCESS, honours PREADY wait states and ends in error after TIMEOUT stalled cycles.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*APB_AW-1:0] req_addr,
  input  logic [NREQ*APB_DW-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [APB_DW-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [APB_AW-1:0]      PADDR,
  output logic [APB_DW-1:0]      PWDATA,
  input  logic [APB_DW-1:0]      PRDATA,
  input  logic                   PREADY
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e        state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grantIdx_q;
  logic [CW-1:0]     timeoutCnt_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [APB_AW-1:0] paddr_q;
  logic [APB_DW-1:0] pwdata_q;
  logic [NREQ-1:0]   rspValid_q;
  logic [APB_DW-1:0] rspRdata_q;
  logic              rspErr_q;

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gntIdx;
  logic              arbEn;
  logic [IW-1:0]     ptr_d;
  logic [NREQ-1:0]   rspOneHot_d;

  // Gating with PRESETn keeps req_ready low while reset is asserted.
  assign arbEn = (state_q == IDLE) && PRESETn;

  rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_rr (
    .req(req_valid),
    .ptr(ptr_q),
    .en (arbEn),
    .gnt(gnt),
    .idx(gntIdx)
  );

  assign ptr_d = (gntIdx == IW'(NREQ - 1)) ? '0 : gntIdx + 1'b1;

  always_comb begin
    rspOneHot_d             = '0;
    rspOneHot_d[grantIdx_q] = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grantIdx_q   <= '0;
      timeoutCnt_q <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rspValid_q   <= '0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
    end else begin
      rspValid_q <= '0;
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            grantIdx_q <= gntIdx;
            paddr_q    <= req_addr[gntIdx*APB_AW +: APB_AW];
            pwdata_q   <= req_wdata[gntIdx*APB_DW +: APB_DW];
            pwrite_q   <= req_write[gntIdx];
            ptr_q      <= ptr_d;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          penable_q    <= 1'b1;
          timeoutCnt_q <= '0;
          state_q      <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a ready on the last allowed cycle still completes normally.
          if (PREADY) begin
            rspValid_q <= rspOneHot_d;
            rspRdata_q <= pwrite_q ? '0 : PRDATA;
            rspErr_q   <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            state_q    <= IDLE;
          end else if (timeoutCnt_q == CW'(TIMEOUT - 1)) begin
            rspValid_q <= rspOneHot_d;
            rspRdata_q <= ERR_RDATA;
            rspErr_q   <= 1'b1;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            state_q    <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a one-register slave at address 0 and
// programmable PREADY wait states / stuck-low mode.
module tb_apb_master_arbiter;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] slaveReg0;
  int          waitStates;
  logic        stuckLow;
  int          accCnt;

  apb_master_arbiter #(
    .NREQ   (2),
    .TIMEOUT(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave: register at 0x0, everything else reads DEADBEEF; PREADY rises after waitStates ACCESS cycles.
  assign PRDATA = (PADDR == 32'h0) ? slaveReg0 : 32'hDEADBEEF;
  assign PREADY = !stuckLow && (accCnt >= waitStates);

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) accCnt <= accCnt + 1;
    else accCnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 32'h0) slaveReg0 <= PWDATA;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the rsp_valid cycle.
  task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int accCycles);
    int n;
    req_valid[idx]          = 1'b1;
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wdata;
    #1;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 50) begin
      @(posedge PCLK); #1;
      n++;
    end
    checkOutput("accept", {31'b0, req_ready[idx]}, 32'd1);
    @(posedge PCLK); #1;
    req_valid[idx] = 1'b0;
    accCycles = 0;
    n = 0;
    while (rsp_valid[idx] !== 1'b1 && n < 60) begin
      if (PENABLE) begin
        accCycles++;
        checkOutput("paddr_stable", PADDR, addr);
      end
      @(posedge PCLK); #1;
      n++;
    end
    checkOutput("rsp_valid", {30'b0, rsp_valid}, 32'd1 << idx);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acc;
    logic [1:0]  grants[4];
    int          g;
    int          firstCyc;
    int          lastCyc;
    int          n;

    PRESETn    = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    waitStates = 0;
    stuckLow   = 1'b0;
    slaveReg0  = 32'h0;
    accCnt     = 0;

    repeat (3) @(posedge PCLK);
    #1;
    checkOutput("rst_psel", {31'b0, PSEL}, 32'd0);
    checkOutput("rst_penable", {31'b0, PENABLE}, 32'd0);
    checkOutput("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_paddr", PADDR, 32'd0);
    checkOutput("rst_req_ready", {30'b0, req_ready}, 32'd0);
    PRESETn = 1'b1;

    // T1: cycle-exact write from requester 0
    @(posedge PCLK); #1;
    req_valid[0]      = 1'b1;
    req_write[0]      = 1'b1;
    req_addr[31:0]    = 32'h0;
    req_wdata[31:0]   = 32'h12345678;
    #1;
    checkOutput("t1_c0_ready", {30'b0, req_ready}, 32'd1);
    @(posedge PCLK); #1;
    req_valid[0] = 1'b0;
    checkOutput("t1_c1_psel", {31'b0, PSEL}, 32'd1);
    checkOutput("t1_c1_penable", {31'b0, PENABLE}, 32'd0);
    checkOutput("t1_c1_pwrite", {31'b0, PWRITE}, 32'd1);
    checkOutput("t1_c1_pwdata", PWDATA, 32'h12345678);
    @(posedge PCLK); #1;
    checkOutput("t1_c2_psel", {31'b0, PSEL}, 32'd1);
    checkOutput("t1_c2_penable", {31'b0, PENABLE}, 32'd1);
    checkOutput("t1_c2_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    @(posedge PCLK); #1;
    checkOutput("t1_c3_rsp_valid", {30'b0, rsp_valid}, 32'd1);
    checkOutput("t1_c3_rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("t1_c3_rdata_write", rsp_rdata, 32'd0);
    checkOutput("t1_c3_psel", {31'b0, PSEL}, 32'd0);

    // T3: unmapped read returns slave default
    applyStimulus(0, 1'b0, 32'h4, 32'h0, rd, er, acc);
    checkOutput("t3_rdata", rd, 32'hDEADBEEF);
    checkOutput("t3_err", {31'b0, er}, 32'd0);

    // T2: read-back by requester 1
    applyStimulus(1, 1'b0, 32'h0, 32'h0, rd, er, acc);
    checkOutput("t2_rdata", rd, 32'h12345678);
    checkOutput("t2_err", {31'b0, er}, 32'd0);
    checkOutput("t2_acc_cycles", acc, 32'd1);

    // T4: both requesters held valid for four transfers
    req_write    = 2'b00;
    req_addr     = '0;
    req_valid    = 2'b11;
    #1;
    g        = 0;
    firstCyc = 0;
    lastCyc  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (req_ready != 2'b00) begin
        grants[g] = req_ready;
        if (g == 0) firstCyc = cyc;
        lastCyc = cyc;
        g++;
      end
      if (g == 4) break;
      @(posedge PCLK); #1;
    end
    checkOutput("t4_grant_count", g, 32'd4);
    checkOutput("t4_grant0", {30'b0, grants[0]}, 32'd1);
    checkOutput("t4_grant1", {30'b0, grants[1]}, 32'd2);
    checkOutput("t4_grant2", {30'b0, grants[2]}, 32'd1);
    checkOutput("t4_grant3", {30'b0, grants[3]}, 32'd2);
    checkOutput("t4_spacing", lastCyc - firstCyc, 32'd9);
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    checkOutput("t4_last_rsp", {30'b0, rsp_valid}, 32'd2);

    // T5a: three wait states stretch ACCESS to four cycles
    waitStates = 3;
    applyStimulus(0, 1'b1, 32'h0, 32'hA5A5A5A5, rd, er, acc);
    checkOutput("t5_acc_cycles", acc, 32'd4);
    checkOutput("t5_err", {31'b0, er}, 32'd0);
    waitStates = 0;

    // T5b: PREADY stuck low ends in an error completion
    stuckLow = 1'b1;
    applyStimulus(1, 1'b0, 32'h0, 32'h0, rd, er, acc);
    checkOutput("t5_to_acc_cycles", acc, 32'd16);
    checkOutput("t5_to_err", {31'b0, er}, 32'd1);
    checkOutput("t5_to_rdata", rd, 32'hDEADBEEF);
    checkOutput("t5_to_idle_psel", {31'b0, PSEL}, 32'd0);

    // T6: reset during ACCESS after requester 0 was served (pointer at 1)
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    #1;
    checkOutput("t6_accept", {30'b0, req_ready}, 32'd1);
    @(posedge PCLK); #1;
    req_valid[0] = 1'b0;
    @(posedge PCLK); #1;
    checkOutput("t6_in_access", {31'b0, PENABLE}, 32'd1);
    @(posedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("t6_rst_psel", {31'b0, PSEL}, 32'd0);
    checkOutput("t6_rst_penable", {31'b0, PENABLE}, 32'd0);
    checkOutput("t6_rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    #1;
    checkOutput("t6_rst_req_ready", {30'b0, req_ready}, 32'd0);
    stuckLow = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    #1;
    checkOutput("t6_first_grant", {30'b0, req_ready}, 32'd1);
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge PCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
